// File: rtl/key_input_pkg.sv
// Shared types for the keyboard input channel block.
// Holds the per-channel debounce FSM state encoding and the counter sizing helper.
package key_input_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_e;

  // The counter has to hold every value from 0 to deb.
  function automatic int cnt_width(input int deb);
    return (deb < 1) ? 1 : $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Per-channel key-code queue: DEPTH entries, FIFO order, head reads 0 when empty.
// Latency: a push is visible at head the cycle after the write edge.
// Backpressure: the caller gates push/pop (never push when full unless popping too).
module key_fifo
  import key_input_pkg::*;
#(
  parameter int KW    = 5,
  parameter int DEPTH = 1
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          push,
  input  logic [KW-1:0] push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          last,
  output logic [KW-1:0] head
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  // Sized to the pointer range so indexing is exact; pointers wrap at DEPTH.
  logic [KW-1:0]   mem_q [2**PW];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign full  = (cnt_q == CNTW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign last  = (cnt_q == CNTW'(1));
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/key_input_array.sv
// NCH keyboard channels: sync, debounce on smp, queue, one-cycle kyrpt per new head; KEY_RELEASE_RPT_EN adds rls_rpt.
// Latency: push on the DEB-th matching smp edge; chan_code/chan_vld/kyrpt registered one cycle later.
// Backpressure: none upstream; a push into a full queue is dropped and flagged on ovf until rd.
module key_input_array
  import key_input_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int KW    = 5,
  parameter int DEB   = 3,
  parameter int DEPTH = 1
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              smp,
  input  logic [NCH*KW-1:0] key_i,
  input  logic [NCH-1:0]    rd,
  output logic [NCH*KW-1:0] chan_code,
  output logic [NCH-1:0]    chan_vld,
  output logic [NCH-1:0]    kyrpt,
  output logic [NCH-1:0]    ovf,
  output logic              any_rpt
`ifdef KEY_RELEASE_RPT_EN
  , output logic [NCH-1:0]  rls_rpt
`endif
);

  localparam int CW = cnt_width(DEB);

  logic [NCH-1:0] kyrpt_d;
  logic           any_rpt_q, any_rpt_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [KW-1:0] sync1_q, sync2_q, samp;
    logic [KW-1:0] cand_q, cand_d, hld_q, hld_d, push_dat, head;
    logic [CW-1:0] cnt_q, cnt_d;
    key_state_e    state_q, state_d;
    logic          push, push_ok, pop_ok, f_full, f_empty, f_last;
    logic          ky_q, ky_d, ovf_q, ovf_d;
    int            run;

    assign samp = sync2_q;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      hld_d    = hld_q;
      push     = 1'b0;
      push_dat = cand_q;
      run      = 0;
      if (smp) begin
        unique case (state_q)
          IDLE: if (samp != '0) begin
            if (DEB == 1) begin
              push = 1'b1; push_dat = samp; hld_d = samp; cnt_d = '0; state_d = HELD;
            end else begin
              cand_d = samp; cnt_d = CW'(1); state_d = PRESS_DB;
            end
          end
          PRESS_DB: if (samp == cand_q) begin
            run = int'(cnt_q) + 1;
            if (run >= DEB) begin
              push = 1'b1; hld_d = cand_q; cnt_d = '0; state_d = HELD;
            end else begin
              cnt_d = CW'(run);
            end
          end else if (samp == '0) begin
            cnt_d = '0; state_d = IDLE;
          end else begin
            cand_d = samp; cnt_d = CW'(1);
          end
          HELD: if (samp != hld_q) begin
            if (DEB == 1 && samp == '0) begin
              cnt_d = '0; state_d = IDLE;
            end else begin
              cand_d = samp; cnt_d = CW'(1); state_d = REL_DB;
            end
          end
          // cand == 0 marks that cnt is counting a run of zero samples.
          REL_DB: if (samp == hld_q) begin
            cnt_d = '0; state_d = HELD;
          end else if (samp == '0) begin
            run = (cand_q == '0) ? int'(cnt_q) + 1 : 1;
            if (run >= DEB) begin
              cnt_d = '0; state_d = IDLE;
            end else begin
              cand_d = '0; cnt_d = CW'(run);
            end
          end else if (DEB == 1) begin
            push = 1'b1; push_dat = samp; hld_d = samp; cnt_d = '0; state_d = HELD;
          end else begin
            cand_d = samp; cnt_d = CW'(1); state_d = PRESS_DB;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Pop is applied before push, so a full queue with rd still accepts the new code.
    always_comb begin
      pop_ok  = rd[i] & ~f_empty;
      push_ok = push & (~f_full | pop_ok);
      ky_d    = (push_ok & f_empty) | (pop_ok & (push_ok | ~f_last));
      ovf_d   = ovf_q;
      if (rd[i])            ovf_d = 1'b0;
      if (push && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge CLOCK) begin
      if (!rst) begin
        sync1_q <= '0;
        sync2_q <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        cand_q  <= '0;
        hld_q   <= '0;
        ky_q    <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        sync1_q <= key_i[i*KW +: KW];
        sync2_q <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cand_q  <= cand_d;
        hld_q   <= hld_d;
        ky_q    <= ky_d;
        ovf_q   <= ovf_d;
      end
    end

    key_fifo #(.KW(KW), .DEPTH(DEPTH)) u_fifo (
      .CLOCK    (CLOCK),
      .rst      (rst),
      .push     (push_ok),
      .push_dat (push_dat),
      .pop      (pop_ok),
      .full     (f_full),
      .empty    (f_empty),
      .last     (f_last),
      .head     (head)
    );

    assign kyrpt_d[i]            = ky_d;
    assign chan_code[i*KW +: KW] = head;
    assign chan_vld[i]           = ~f_empty;
    assign kyrpt[i]              = ky_q;
    assign ovf[i]                = ovf_q;

`ifdef KEY_RELEASE_RPT_EN
    logic rls_q, rls_d;

    always_comb begin
      rls_d = (state_q == HELD || state_q == REL_DB) && (state_d == IDLE);
    end

    always_ff @(posedge CLOCK) begin
      if (!rst) rls_q <= 1'b0;
      else      rls_q <= rls_d;
    end

    assign rls_rpt[i] = rls_q;
`endif
  end

  always_comb begin
    any_rpt_d = |kyrpt_d;
  end

  always_ff @(posedge CLOCK) begin
    if (!rst) any_rpt_q <= 1'b0;
    else      any_rpt_q <= any_rpt_d;
  end

  assign any_rpt = any_rpt_q;

endmodule

// File: tb/tb_key_input_array.sv
// Directed bench for key_input_array: DEPTH=1 and DEPTH=2 instances share clock, reset, smp and keys.
// Release reporting is exercised when KEY_RELEASE_RPT_EN is defined.
module tb_key_input_array;

  logic       clk = 1'b0;
  logic       rst, smp;
  logic [9:0] key_i;
  logic [1:0] rd, rd2;

  logic [9:0] chan_code, chan_code2;
  logic [1:0] chan_vld, chan_vld2, kyrpt, kyrpt2, ovf, ovf2;
  logic       any_rpt, any_rpt2;
`ifdef KEY_RELEASE_RPT_EN
  logic [1:0] rls_rpt, rls_rpt2;
`endif

  int n_chk = 0, n_fail = 0;
  int ky0_cnt = 0, ky2_cnt = 0, rls0_cnt = 0;
  int base;

  always #5 clk = ~clk;

  key_input_array #(.NCH(2), .KW(5), .DEB(3), .DEPTH(1)) dut (
    .CLOCK(clk), .rst(rst), .smp(smp), .key_i(key_i), .rd(rd),
    .chan_code(chan_code), .chan_vld(chan_vld), .kyrpt(kyrpt), .ovf(ovf), .any_rpt(any_rpt)
`ifdef KEY_RELEASE_RPT_EN
    , .rls_rpt(rls_rpt)
`endif
  );

  key_input_array #(.NCH(2), .KW(5), .DEB(3), .DEPTH(2)) dut2 (
    .CLOCK(clk), .rst(rst), .smp(smp), .key_i(key_i), .rd(rd2),
    .chan_code(chan_code2), .chan_vld(chan_vld2), .kyrpt(kyrpt2), .ovf(ovf2), .any_rpt(any_rpt2)
`ifdef KEY_RELEASE_RPT_EN
    , .rls_rpt(rls_rpt2)
`endif
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (kyrpt[0])  ky0_cnt++;
    if (kyrpt2[0]) ky2_cnt++;
`ifdef KEY_RELEASE_RPT_EN
    if (rls_rpt[0]) rls0_cnt++;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; smp = 1'b0; key_i = '0; rd = '0; rd2 = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Present a key pattern, let it cross the synchroniser, then one smp (optional rd2 alongside).
  task automatic smp_key(input logic [9:0] k, input logic [1:0] r2);
    key_i = k;
    tick(); tick();
    smp = 1'b1; rd2 = r2;
    tick();
    smp = 1'b0; rd2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; smp = 1'b0; key_i = '0; rd = '0; rd2 = '0;
    tick();
    n_chk++; if (chan_code !== 10'd0) begin n_fail++; $display("FAIL rst_code: got %h want 0", chan_code); end
    n_chk++; if (chan_vld !== 2'b00) begin n_fail++; $display("FAIL rst_vld: got %b want 00", chan_vld); end
    n_chk++; if (kyrpt !== 2'b00) begin n_fail++; $display("FAIL rst_kyrpt: got %b want 00", kyrpt); end
    n_chk++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL rst_ovf: got %b want 00", ovf); end
    n_chk++; if (any_rpt !== 1'b0) begin n_fail++; $display("FAIL rst_any: got %b want 0", any_rpt); end
`ifdef KEY_RELEASE_RPT_EN
    n_chk++; if (rls_rpt !== 2'b00) begin n_fail++; $display("FAIL rst_rls: got %b want 00", rls_rpt); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_single_press();
    apply_reset();
    base = ky0_cnt;
    repeat (3) smp_key({5'd0, 5'd7}, 2'b00);
    n_chk++; if (chan_code !== {5'd0, 5'd7}) begin n_fail++; $display("FAIL press_code: got %h want 007", chan_code); end
    n_chk++; if (chan_vld !== 2'b01) begin n_fail++; $display("FAIL press_vld: got %b want 01", chan_vld); end
    n_chk++; if (kyrpt !== 2'b01) begin n_fail++; $display("FAIL press_kyrpt: got %b want 01", kyrpt); end
    n_chk++; if (any_rpt !== 1'b1) begin n_fail++; $display("FAIL press_any: got %b want 1", any_rpt); end
    smp_key({5'd0, 5'd7}, 2'b00);
    tick();
    n_chk++; if (ky0_cnt - base !== 1) begin n_fail++; $display("FAIL press_pulses: got %0d want 1", ky0_cnt - base); end
    n_chk++; if (chan_code !== {5'd0, 5'd7}) begin n_fail++; $display("FAIL press_hold_code: got %h want 007", chan_code); end
  endtask

  task automatic test_bounce();
    apply_reset();
    base = ky0_cnt;
    smp_key(10'd7, 2'b00);
    smp_key(10'd0, 2'b00);
    smp_key(10'd7, 2'b00);
    smp_key(10'd7, 2'b00);
    n_chk++; if (chan_vld[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_early: got %b want 0", chan_vld[0]); end
    smp_key(10'd7, 2'b00);
    n_chk++; if (chan_vld[0] !== 1'b1) begin n_fail++; $display("FAIL bounce_vld: got %b want 1", chan_vld[0]); end
    n_chk++; if (chan_code[4:0] !== 5'd7) begin n_fail++; $display("FAIL bounce_code: got %0d want 7", chan_code[4:0]); end
    tick();
    n_chk++; if (ky0_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 1", ky0_cnt - base); end
  endtask

  task automatic test_overrun();
    apply_reset();
    base = ky0_cnt;
    repeat (3) smp_key(10'd3, 2'b00);
    repeat (3) smp_key(10'd0, 2'b00);
    repeat (3) smp_key(10'd4, 2'b00);
    n_chk++; if (chan_code[4:0] !== 5'd3) begin n_fail++; $display("FAIL ovr_code: got %0d want 3", chan_code[4:0]); end
    n_chk++; if (ovf !== 2'b01) begin n_fail++; $display("FAIL ovr_flag: got %b want 01", ovf); end
    rd = 2'b01;
    tick();
    rd = 2'b00;
    n_chk++; if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovf[0]); end
    n_chk++; if (chan_vld[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_vld: got %b want 0", chan_vld[0]); end
    n_chk++; if (chan_code[4:0] !== 5'd0) begin n_fail++; $display("FAIL ovr_pop_code: got %0d want 0", chan_code[4:0]); end
    n_chk++; if (kyrpt[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_kyrpt: got %b want 0", kyrpt[0]); end
    tick();
    n_chk++; if (ky0_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ky0_cnt - base); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    base = ky2_cnt;
    repeat (3) smp_key(10'd1, 2'b00);
    repeat (3) smp_key(10'd0, 2'b00);
    repeat (3) smp_key(10'd2, 2'b00);
    repeat (3) smp_key(10'd0, 2'b00);
    repeat (2) smp_key(10'd9, 2'b00);
    smp_key(10'd9, 2'b01);
    n_chk++; if (chan_code2[4:0] !== 5'd2) begin n_fail++; $display("FAIL full_head: got %0d want 2", chan_code2[4:0]); end
    n_chk++; if (ovf2[0] !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b want 0", ovf2[0]); end
    n_chk++; if (kyrpt2[0] !== 1'b1) begin n_fail++; $display("FAIL full_kyrpt: got %b want 1", kyrpt2[0]); end
    rd2 = 2'b01;
    tick();
    rd2 = 2'b00;
    n_chk++; if (chan_code2[4:0] !== 5'd9) begin n_fail++; $display("FAIL full_next: got %0d want 9", chan_code2[4:0]); end
    n_chk++; if (chan_vld2 !== 2'b01) begin n_fail++; $display("FAIL full_vld: got %b want 01", chan_vld2); end
    tick();
    n_chk++; if (ky2_cnt - base !== 3) begin n_fail++; $display("FAIL full_pulses: got %0d want 3", ky2_cnt - base); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (3) smp_key({5'd2, 5'd0}, 2'b00);
    repeat (2) smp_key({5'd2, 5'd5}, 2'b00);
    key_i = {5'd0, 5'd5};
    rst = 1'b0;
    tick();
    n_chk++; if (chan_vld !== 2'b00) begin n_fail++; $display("FAIL mid_rst_vld: got %b want 00", chan_vld); end
    n_chk++; if (chan_code !== 10'd0) begin n_fail++; $display("FAIL mid_rst_code: got %h want 0", chan_code); end
    n_chk++; if (any_rpt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_any: got %b want 0", any_rpt); end
    rst = 1'b1;
    smp_key({5'd0, 5'd5}, 2'b00);
    n_chk++; if (chan_vld[0] !== 1'b0) begin n_fail++; $display("FAIL mid_s1: got %b want 0", chan_vld[0]); end
    smp_key({5'd0, 5'd5}, 2'b00);
    n_chk++; if (chan_vld[0] !== 1'b0) begin n_fail++; $display("FAIL mid_s2: got %b want 0", chan_vld[0]); end
    smp_key({5'd0, 5'd5}, 2'b00);
    n_chk++; if (chan_code !== {5'd0, 5'd5}) begin n_fail++; $display("FAIL mid_s3: got %h want 005", chan_code); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    repeat (3) smp_key({5'd22, 5'd11}, 2'b00);
    n_chk++; if (chan_code !== {5'd22, 5'd11}) begin n_fail++; $display("FAIL b2b_code: got %h want %h", chan_code, {5'd22, 5'd11}); end
    n_chk++; if (kyrpt !== 2'b11) begin n_fail++; $display("FAIL b2b_kyrpt: got %b want 11", kyrpt); end
    rd = 2'b11;
    tick();
    rd = 2'b00;
    n_chk++; if (chan_vld !== 2'b00) begin n_fail++; $display("FAIL b2b_pop_vld: got %b want 00", chan_vld); end
    n_chk++; if (kyrpt !== 2'b00) begin n_fail++; $display("FAIL b2b_pop_kyrpt: got %b want 00", kyrpt); end
  endtask

`ifdef KEY_RELEASE_RPT_EN
  task automatic test_release();
    apply_reset();
    base = rls0_cnt;
    repeat (3) smp_key(10'd6, 2'b00);
    repeat (2) smp_key(10'd0, 2'b00);
    n_chk++; if (rls_rpt[0] !== 1'b0) begin n_fail++; $display("FAIL rls_early: got %b want 0", rls_rpt[0]); end
    smp_key(10'd0, 2'b00);
    n_chk++; if (rls_rpt !== 2'b01) begin n_fail++; $display("FAIL rls_pulse: got %b want 01", rls_rpt); end
    tick();
    n_chk++; if (rls_rpt[0] !== 1'b0) begin n_fail++; $display("FAIL rls_width: got %b want 0", rls_rpt[0]); end
    n_chk++; if (rls0_cnt - base !== 1) begin n_fail++; $display("FAIL rls_pulses: got %0d want 1", rls0_cnt - base); end
    n_chk++; if (chan_code[4:0] !== 5'd6) begin n_fail++; $display("FAIL rls_code: got %0d want 6", chan_code[4:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_overrun();
    test_full_push_pop();
    test_reset_mid();
    test_back_to_back();
`ifdef KEY_RELEASE_RPT_EN
    test_release();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_input_array.md
# key_input_array

Parametrised keyboard input channel block: NCH independent key-code inputs (DSKY/nav keyboards) are synchronised, debounced on a slow sample strobe, queued per channel and presented as input-channel words with a one-cycle key-interrupt request (KYRPT-style) per new code. It is the next-generation replacement for the fixed two-keyboard channel 15/16 logic. It adds arbitrary channel count, key-code width, debounce length, per-channel queue depth and overrun reporting.

## Interface
- NCH, 2: number of keyboard channels (≥1)
- KW, 5: key-code width in bits; code 0 means "no key"
- DEB, 3: consecutive equal samples required to accept press or release (≥1)
- DEPTH, 1: per-channel queue depth (≥1; 1 = single latch)

- CLOCK  in  1  system clock
- rst  in  1  synchronous, active-low reset
- smp  in  1  one-cycle debounce sample strobe (F09-class timing pulse)
- key_i  in  NCH*KW  raw asynchronous key codes, channel i at [i*KW +: KW]
- rd  in  NCH  one-cycle read/pop strobe per channel
- chan_code  out  NCH*KW  head-of-queue code per channel; 0 when empty
- chan_vld  out  NCH  queue non-empty
- kyrpt  out  NCH  one-cycle interrupt request: new head became valid
- ovf  out  NCH  sticky overrun flag
- any_rpt  out  1  OR of kyrpt
- rls_rpt  out  NCH  one-cycle release event (only with KEY_RELEASE_RPT_EN)

## Operation
- Each key_i channel passes through a 2-flop synchroniser; only the synchronised value is sampled, and only on cycles with smp=1.
- Per-channel FSM (counter cnt, 0..DEB; candidate cand; held code hld):
  - IDLE: sample nonzero → PRESS_DB, cand=sample, cnt=1 (if DEB=1: accept immediately).
  - PRESS_DB: sample==cand → cnt+1; on reaching DEB → push cand, hld=cand, HELD. Sample≠cand: if zero → IDLE; else cand=sample, cnt=1.
  - HELD: sample≠hld → REL_DB, cand=sample, cnt=1.
  - REL_DB: sample==hld → HELD. Sample zero for DEB consecutive samples → IDLE (release event). Sample nonzero≠hld → PRESS_DB, cand=sample, cnt=1.
- Queue per channel, DEPTH entries, FIFO order. Push when full: drop the code, set ovf. Push and rd in the same cycle when full: pop first, push succeeds, no ovf. rd when empty: ignored, including when a push occurs in the same cycle.
- kyrpt[i] pulses the cycle after the head changes to a new valid entry: empty→non-empty push, or pop leaving the queue non-empty.
- ovf[i] clears on rd[i] (rd wins over a simultaneous overrun set: ovf stays 0 for that cycle's drop? No—a set in the same cycle as rd leaves ovf=1).
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset (rst=0 at a CLOCK edge): all FSMs IDLE, counters 0, queues empty, synchronisers 0. chan_code=0, chan_vld=0, kyrpt=0, ovf=0, any_rpt=0, rls_rpt=0.
- Reset mid-debounce or with a queued code discards everything; the first sample after reset starts fresh.
- Latency: key_i stable → 2 cycles sync → accepted on the DEB-th qualifying smp cycle; push registered at that edge; chan_code/chan_vld valid the next cycle; kyrpt high in that same next cycle for exactly one cycle.
- Pop: chan_code shows the next entry (or 0) the cycle after rd.
- Outputs are all registered; no combinational path from inputs to outputs.

## Configuration
- KEY_RELEASE_RPT_EN defined: the rls_rpt port exists. rls_rpt[i] pulses for one cycle, the cycle after REL_DB→IDLE. It does not touch the queue.
- Undefined: rls_rpt is absent, and release is silent; the FSM is identical.

## Structure
- Package key_input_pkg: FSM state enum (IDLE, PRESS_DB, HELD, REL_DB), the state width, and a function computing the counter width from DEB.
- Sub-module key_fifo (parameters KW, DEPTH): push/pop/full/empty/head, with a pointer wrap at DEPTH (non-power-of-two allowed). One instance per channel, generated by a loop over NCH.

## Test plan
- NCH=2, DEB=3: key_i[0]=5'd7 held for 4 smp → chan_code[0]=7, chan_vld[0]=1, single kyrpt[0] pulse one cycle after the 3rd sample; channel 1 unaffected.
- Bounce 7,0,7,7,7 on channel 0 → exactly one push of 7, after the final 3rd consecutive sample.
- DEPTH=1: press 3, release, press 4 with no rd → chan_code=3, ovf=1. Then rd → ovf=0, chan_code=0, vld=0, and no kyrpt.
- DEPTH=2: push 1,2, then rd coincident with push of 9 when full → queue 2,9, ovf=0, kyrpt after the pop.
- Assert rst=0 during PRESS_DB with count 2 → all outputs 0 next cycle; the same key needs a full DEB samples again.
- KEY_RELEASE_RPT_EN: press 6 accepted, then zero for 3 samples → rls_rpt[0] single pulse, and chan_code still 6.
